jtag_host: RTL and testbench



---
 rtl/jtag_host.sv | 193 +++++++++++++++++++
 tb/tb_jtag_host.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host.sv
// JTAG initiator: walks the TAP, shifts IR/DR scans LSB-first, captures TDO.
// Optional: JTAG_HOST_RUNTEST_EN enables op 11 (run-test TCK bursts).
module jtag_host #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtagTCK,
  output logic               jtagTMS,
  output logic               jtagTDI,
  input  logic               jtagTDO
);

  typedef enum logic [2:0] {
    IDLE, RESET, PRE, SHIFT, POST, DONE
  } state_t;

  localparam logic [7:0] DIVM = 8'(CLK_DIV - 1);
  localparam logic [5:0] MAXL = 6'(MAX_LEN);

  state_t state, stateNext, startState;
  logic [7:0] div;
  logic phase;
  logic [5:0] cnt, cntNext;
  logic [1:0] opR;
  logic [5:0] lenR;
  logic [MAX_LEN-1:0] dataR, capR;
  logic skip, tmsR, tdiR;
  logic accept, ticking, bitEnd, lenBad, loadBit;
  logic [1:0] opS;
  logic [5:0] lenS;
  logic [MAX_LEN-1:0] dataS;

  function automatic logic tmsOf(state_t s, logic [5:0] c,
                                 logic [1:0] op, logic [5:0] len);
    logic t;
    t = 1'b0;
    case (s)
      RESET:   t = c < 6'd5;
      PRE:     t = (op == 2'b01) ? (c < 6'd2) : (c == 6'd0);
      SHIFT:   t = (op != 2'b11) && (c == len - 6'd1);
      POST:    t = c == 6'd0;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic tdiOf(state_t s, logic [5:0] c,
                                 logic [1:0] op, logic [MAX_LEN-1:0] d);
    logic [MAX_LEN-1:0] sh;
    sh = d >> c;
    return (s == SHIFT) && (op != 2'b11) && sh[0];
  endfunction

  assign cmd_ready = (state == IDLE) || (state == DONE);
  assign busy      = !cmd_ready;
  assign rsp_valid = state == DONE;
  assign jtagTCK   = phase;
  assign jtagTMS   = tmsR;
  assign jtagTDI   = tdiR;
  assign accept    = cmd_valid && cmd_ready;

  assign ticking = !skip && (state == RESET || state == PRE ||
                             state == SHIFT || state == POST);
  assign bitEnd  = ticking && phase && (div == DIVM);

  always_comb begin
    lenBad = (cmd_len == 6'd0) || (cmd_len > MAXL);
    startState = PRE;
    case (cmd_op)
      2'b00: begin
        lenBad = 1'b0;
        startState = RESET;
      end
`ifdef JTAG_HOST_RUNTEST_EN
      2'b11: begin
        lenBad = cmd_len == 6'd0;
        startState = lenBad ? PRE : SHIFT;
      end
`else
      2'b11: lenBad = 1'b1;
`endif
      default: startState = PRE;
    endcase
  end

  always_comb begin
    stateNext = state;
    cntNext = cnt;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          stateNext = startState;
          cntNext = '0;
        end else if (state == DONE) begin
          stateNext = IDLE;
        end
      end
      RESET: if (bitEnd) begin
        if (cnt == 6'd5) stateNext = DONE;
        else cntNext = cnt + 6'd1;
      end
      PRE: begin
        if (skip) begin
          stateNext = DONE;
        end else if (bitEnd) begin
          if (cnt == ((opR == 2'b01) ? 6'd3 : 6'd2)) begin
            stateNext = SHIFT;
            cntNext = '0;
          end else begin
            cntNext = cnt + 6'd1;
          end
        end
      end
      SHIFT: if (bitEnd) begin
        if (cnt == lenR - 6'd1) begin
          stateNext = (opR == 2'b11) ? DONE : POST;
          cntNext = '0;
        end else begin
          cntNext = cnt + 6'd1;
        end
      end
      POST: if (bitEnd) begin
        if (cnt == 6'd1) stateNext = DONE;
        else cntNext = cnt + 6'd1;
      end
      default: stateNext = IDLE;
    endcase
  end

  // New bit values come from the command inputs on the accept cycle.
  assign opS     = accept ? cmd_op : opR;
  assign lenS    = accept ? cmd_len : lenR;
  assign dataS   = accept ? cmd_data : dataR;
  assign loadBit = (accept && !lenBad) ||
                   (bitEnd && stateNext != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div      <= '0;
      phase    <= 1'b0;
      tmsR     <= 1'b1;
      tdiR     <= 1'b0;
      opR      <= '0;
      lenR     <= '0;
      dataR    <= '0;
      capR     <= '0;
      skip     <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        opR   <= cmd_op;
        lenR  <= cmd_len;
        dataR <= cmd_data;
        skip  <= lenBad;
        capR  <= '0;
      end
      if (ticking) begin
        if (div == DIVM) begin
          div   <= '0;
          phase <= ~phase;
        end else begin
          div <= div + 8'd1;
        end
      end else begin
        div   <= '0;
        phase <= 1'b0;
      end
      if (loadBit) begin
        tmsR <= tmsOf(stateNext, cntNext, opS, lenS);
        tdiR <= tdiOf(stateNext, cntNext, opS, dataS);
      end
      if (bitEnd && state == SHIFT && opR != 2'b11)
        capR <= capR | (MAX_LEN'(jtagTDO) << cnt);
      if (stateNext == DONE)
        rsp_data <= capR;
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Randomized bench for jtag_host against a TAP-sequence reference model.
// A simple target drives TDO on TCK falls; every TCK rise is logged.
module tb_jtag_host;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [5:0] cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic rsp_valid;
  logic [31:0] rsp_data;
  logic busy, jtagTCK, jtagTMS, jtagTDI;
  logic jtagTDO = 1'b0;

  int checks = 0;
  int errors = 0;
  int tdoMode = 0;
  logic lastTdi = 1'b0;
  logic tmsQ[$];
  logic tdiQ[$];
  logic tdoQ[$];

  always #5 clk = ~clk;

  jtag_host #(.CLK_DIV(4), .MAX_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .jtagTCK(jtagTCK), .jtagTMS(jtagTMS),
    .jtagTDI(jtagTDI), .jtagTDO(jtagTDO)
  );

  always @(posedge jtagTCK) begin
    tmsQ.push_back(jtagTMS);
    tdiQ.push_back(jtagTDI);
    tdoQ.push_back(jtagTDO);
    lastTdi = jtagTDI;
  end

  always @(negedge jtagTCK) begin
    if (tdoMode == 0) jtagTDO <= lastTdi;
    else if (tdoMode == 1) jtagTDO <= 1'($urandom_range(0, 1));
    else jtagTDO <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected TAP activity from the command alone.
  task automatic model(input logic [1:0] op, input int len,
                       input logic [31:0] data,
                       output int nPre, output int nShift,
                       output int nTck, output logic [63:0] tms,
                       output logic [63:0] tdi);
    logic [63:0] m;
    nPre = 0; nShift = 0; nTck = 0; tms = '0; tdi = '0;
    if (op == 2'b00) begin
      nTck = 6;
      tms = 64'h1F;
    end else if (op != 2'b11 && len >= 1 && len <= 32) begin
      nPre = (op == 2'b01) ? 4 : 3;
      nShift = len;
      nTck = nPre + len + 2;
      tms = (op == 2'b01) ? 64'h3 : 64'h1;
      tms[nPre + len - 1] = 1'b1;
      tms[nPre + len] = 1'b1;
      m = (64'd1 << len) - 64'd1;
      tdi = ({32'd0, data} & m) << nPre;
    end
`ifdef JTAG_HOST_RUNTEST_EN
    else if (op == 2'b11 && len >= 1) begin
      nTck = len;
    end
`endif
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] len,
                       input logic [31:0] data, input bit hold);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("readyTimeout", 0, 1);
    @(posedge clk);
    tmsQ.delete(); tdiQ.delete(); tdoQ.delete();
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic finishCmd(input logic [1:0] op, input logic [5:0] len,
                           input logic [31:0] data, input string tag);
    int n, nPre, nShift, nTck;
    logic [63:0] eTms, eTdi, oTms, oTdi;
    logic [31:0] eRsp;
    model(op, int'(len), data, nPre, nShift, nTck, eTms, eTdi);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 4000);
    chk({tag, ".rspSeen"}, 64'(rsp_valid), 1);
    if (!rsp_valid) return;
    if (nTck == 0) chk({tag, ".zeroLat"}, 64'(n), 2);
    chk({tag, ".tckCount"}, 64'(tmsQ.size()), 64'(nTck));
    oTms = '0; oTdi = '0;
    for (int i = 0; i < tmsQ.size() && i < 64; i++) begin
      oTms[i] = tmsQ[i];
      oTdi[i] = tdiQ[i];
    end
    eRsp = '0;
    for (int i = 0; i < nShift; i++)
      if (nPre + i < tdoQ.size()) eRsp[i] = tdoQ[nPre + i];
    chk({tag, ".tms"}, oTms, eTms);
    chk({tag, ".tdi"}, oTdi, eTdi);
    chk({tag, ".rsp"}, 64'(rsp_data), 64'(eRsp));
    chk({tag, ".readyDone"}, 64'(cmd_ready), 1);
  endtask

  task automatic runCmd(input logic [1:0] op, input logic [5:0] len,
                        input logic [31:0] data, input string tag);
    issue(op, len, data, 1'b0);
    finishCmd(op, len, data, tag);
    @(negedge clk);
    chk({tag, ".pulse"}, 64'(rsp_valid), 0);
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] len;
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.vals", {58'd0, cmd_ready, busy, rsp_valid,
                     jtagTCK, jtagTMS, jtagTDI}, 64'b100010);
    chk("rst.rsp", 64'(rsp_data), 0);

    tdoMode = 1;
    runCmd(2'b00, 6'd0, 32'd0, "tapReset");
    chk("tapReset.rspZero", 64'(rsp_data), 0);

    tdoMode = 0;
    runCmd(2'b10, 6'd8, 32'hA5, "drA5");
    chk("drA5.loop", 64'(rsp_data), 64'h4A);

    tdoMode = 2;
    runCmd(2'b01, 6'd4, 32'h1, "ir4");
    chk("ir4.ones", 64'(rsp_data), 64'hF);

    tdoMode = 1;
    runCmd(2'b10, 6'd0, 32'hFFFF, "len0");
    runCmd(2'b10, 6'd40, 32'hFFFF, "len40");
    runCmd(2'b11, 6'd5, 32'h0, "runTest");

    // back-to-back: second DR accepted in the first's rsp cycle
    tdoMode = 0;
    issue(2'b10, 6'd6, 32'h2D, 1'b1);
    finishCmd(2'b10, 6'd6, 32'h2D, "b2bA");
    cmd_data = 32'h13; cmd_len = 6'd5;
    @(posedge clk);
    tmsQ.delete(); tdiQ.delete(); tdoQ.delete();
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b.busy", 64'(busy), 1);
    chk("b2b.tckLow", 64'(jtagTCK), 0);
    finishCmd(2'b10, 6'd5, 32'h13, "b2bB");

    // reset mid-scan
    issue(2'b10, 6'd32, 32'hDEADBEEF, 1'b0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midRst.vals", {58'd0, cmd_ready, busy, rsp_valid,
                        jtagTCK, jtagTMS, jtagTDI}, 64'b100010);
    chk("midRst.rsp", 64'(rsp_data), 0);
    runCmd(2'b00, 6'd0, 32'd0, "postRst");

    for (int k = 0; k < 30; k++) begin
      op = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r == 0) len = 6'd0;
      else if (r == 1) len = 6'($urandom_range(33, 63));
      else len = 6'($urandom_range(1, 32));
      tdoMode = $urandom_range(0, 2);
      runCmd(op, len, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
